// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared types and constants for the instruction fetch stage
package instr_fetch_pkg;
  typedef logic [31:0] word_t;
  typedef struct packed {
    word_t pc;
    word_t inst;
    logic  misalign;
  } fetch_entry_t;
  localparam word_t NOP_INST = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} fetch_state_e;
endpackage

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: small sync FIFO of fetch entries with flush, head exposed from storage
module instr_fetch_buffer
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t wr_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [AW:0]  count
);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_pop, do_push;
  assign do_pop = pop && !flush && count != '0;
  assign do_push = push && !flush && (count != FULL || do_pop);
  assign head = mem[rd_ptr];
  // pointer and occupancy bookkeeping; flush empties the queue in one edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(do_pop);
      wr_ptr <= wr_ptr + AW'(do_push);
      count  <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  // entry storage needs no reset: contents are only observed when count is nonzero
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage issuing one imem read per PC and buffering {pc, inst} for decode
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  output logic        dec_misalign
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  fetch_state_e state;
  word_t pc_q;
  logic [CW-1:0] count;
  fetch_entry_t head, push_data;
  logic slot_free, aligned, granted, push, pop, inflight;
  // request, next-PC and push decisions; a slot is only claimed when the FIFO can take it
  always_comb begin
    slot_free = count < CW'(BUF_DEPTH);
    aligned   = pc[1:0] == 2'b00;
    imem_req  = state == REQ && slot_free && aligned;
    granted   = imem_req && imem_gnt;
    next_pc   = redirect ? redirect_pc : granted ? pc + 32'd4 : pc;
    push      = !redirect && ((state == REQ && slot_free && !aligned) || (state == WAIT && imem_rvalid));
    push_data = state == WAIT ? '{pc: pc_q, inst: imem_rdata, misalign: 1'b0}
                              : '{pc: pc, inst: NOP_INST, misalign: 1'b1};
    // a response is still owed after this edge unless it arrives in this very cycle
    inflight  = granted || ((state == WAIT || state == DRAIN) && !imem_rvalid);
  end
  assign imem_addr    = pc;
  assign pop          = dec_valid && dec_ready;
  assign dec_valid    = count != '0;
  assign dec_pc       = head.pc;
  assign dec_inst     = head.inst;
  assign dec_misalign = head.misalign;
  // fetch control FSM; redirect with a read outstanding parks in DRAIN to swallow the stale reply
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc_q  <= '0;
    end else begin
      if (granted) pc_q <= pc;
      state <= redirect ? (inflight ? DRAIN : REQ)
             : state == IDLE ? REQ
             : state == REQ ? (granted ? WAIT : REQ)
             : imem_rvalid ? REQ : state;
    end
  instr_fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (push_data),
    .pop     (pop),
    .flush   (redirect),
    .head    (head),
    .count   (count)
  );
  a_rvalid_protocol: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> state inside {WAIT, DRAIN});
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch with PC register and imem model
module tb_instr_fetch;
  localparam int DEPTH = 2;
  localparam logic [31:0] DOFS = 32'h1000_0000;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] pc, next_pc, redirect_pc = '0, imem_addr, imem_rdata, dec_inst, dec_pc;
  logic redirect = 1'b0, imem_req, imem_gnt, imem_rvalid, dec_valid, dec_ready = 1'b1, dec_misalign;
  logic [1:0] cnt;
  logic [31:0] paddr, nxt;
  int lat = 1;
  int checks = 0, passes = 0;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } ent_t;
  ent_t got[$];
  always #5 clk = ~clk;
  instr_fetch #(.BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .next_pc(next_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst),
    .dec_pc(dec_pc), .dec_misalign(dec_misalign)
  );
  assign imem_gnt    = 1'b1;
  assign imem_rvalid = cnt == 2'd1;
  assign imem_rdata  = paddr + DOFS;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= '0;
    else pc <= next_pc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt   <= '0;
      paddr <= '0;
    end else if (imem_req && imem_gnt) begin
      cnt   <= 2'(lat);
      paddr <= imem_addr;
    end else if (cnt != '0) cnt <= cnt - 2'd1;
  always @(negedge clk)
    if (rst_n && dec_valid && dec_ready && !redirect) got.push_back('{dec_pc, dec_inst, dec_misalign});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_grant(input string tag, input logic need_valid, input logic use_addr, input logic [31:0] addr);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (imem_req && imem_gnt && (dec_valid || !need_valid) && (imem_addr == addr || !use_addr)) break;
    end
    chk(tag, 32'(imem_req && imem_gnt && (dec_valid || !need_valid) && (imem_addr == addr || !use_addr)), 1);
  endtask

  task automatic expect_seq(input string tag, input int n);
    ent_t e;
    for (int i = 0; i < 200 && got.size() < n; i++) @(negedge clk);
    chk({tag, "_count"}, 32'(got.size() >= n), 1);
    for (int k = 0; k < n && got.size() > 0; k++) begin
      e = got.pop_front();
      chk({tag, "_pc"}, e.pc, nxt);
      chk({tag, "_inst"}, e.inst, nxt + DOFS);
      chk({tag, "_mis"}, 32'(e.mis), 0);
      nxt += 32'd4;
    end
  endtask

  initial begin
    ent_t e;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dec_valid", 32'(dec_valid), 0);
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_next_pc", next_pc, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req", 32'(imem_req), 0);
    @(negedge clk);
    chk("first_req", 32'(imem_req), 1);
    chk("first_addr", imem_addr, 0);
    chk("first_next_pc", next_pc, 4);
    @(negedge clk);
    chk("wait_req", 32'(imem_req), 0);
    chk("wait_hold_pc", next_pc, 4);
    @(negedge clk);
    chk("first_dec_valid", 32'(dec_valid), 1);
    chk("first_dec_pc", dec_pc, 0);
    chk("second_next_pc", next_pc, 8);
    nxt = '0;
    expect_seq("seq", 3);
    // decode stall: buffer fills to depth, fetch stops, PC sits DEPTH words ahead of the head
    @(posedge clk); #1 dec_ready = 1'b0;
    repeat (10) @(negedge clk);
    chk("stall_valid", 32'(dec_valid), 1);
    chk("stall_req", 32'(imem_req), 0);
    chk("stall_depth", pc - dec_pc, 4 * DEPTH);
    @(posedge clk); #1 dec_ready = 1'b1;
    expect_seq("resume", 5);
    // redirect while a two-cycle read is pending
    lat = 2;
    wait_grant("wr_find", 1'b0, 1'b0, '0);
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h100; got.delete();
    @(negedge clk);
    chk("wr_next_pc", next_pc, 32'h100);
    chk("wr_no_rvalid", 32'(imem_rvalid), 0);
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    chk("wr_flushed", 32'(dec_valid), 0);
    chk("wr_drain_req", 32'(imem_req), 0);
    chk("wr_stale_rvalid", 32'(imem_rvalid), 1);
    lat = 1;
    nxt = 32'h100;
    expect_seq("wr_post", 3);
    // redirect coinciding with a grant and a decode pop
    wait_grant("gp_find", 1'b1, 1'b0, '0);
    @(posedge clk); #1;
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h200; got.delete();
    @(negedge clk);
    chk("gp_grant", 32'(imem_req && imem_gnt), 1);
    chk("gp_pop", 32'(dec_valid && dec_ready), 1);
    chk("gp_next_pc", next_pc, 32'h200);
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    chk("gp_flushed", 32'(dec_valid), 0);
    chk("gp_drain_req", 32'(imem_req), 0);
    nxt = 32'h200;
    expect_seq("gp_post", 3);
    // misaligned PC produces NOP fault entries without touching memory
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h102; got.delete();
    @(posedge clk); #1 redirect = 1'b0;
    for (int i = 0; i < 50 && got.size() < 2; i++) @(negedge clk);
    chk("mis_count", 32'(got.size() >= 2), 1);
    chk("mis_req", 32'(imem_req), 0);
    chk("mis_hold_pc", next_pc, 32'h102);
    for (int k = 0; k < 2 && got.size() > 0; k++) begin
      e = got.pop_front();
      chk("mis_pc", e.pc, 32'h102);
      chk("mis_inst", e.inst, 32'h0000_0013);
      chk("mis_flag", 32'(e.mis), 1);
    end
    // PC wraps past the top of the address space
    @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; got.delete();
    @(posedge clk); #1 redirect = 1'b0;
    nxt = 32'hFFFF_FFF8;
    wait_grant("wrap_find", 1'b0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_next_pc", next_pc, 32'h0);
    expect_seq("wrap", 4);
    // asynchronous reset in the middle of a read
    @(posedge clk); #1 dec_ready = 1'b0;
    wait_grant("rst_find", 1'b1, 1'b0, '0);
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(dec_valid), 1);
    chk("pre_rst_rvalid", 32'(imem_rvalid), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_dec_valid", 32'(dec_valid), 0);
    chk("arst_imem_req", 32'(imem_req), 0);
    chk("arst_next_pc", next_pc, 0);
    @(posedge clk); #1 rst_n = 1'b1; dec_ready = 1'b1; got.delete();
    nxt = '0;
    expect_seq("post_rst", 2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
